// File: rtl/sram_host_port.sv
// Byte-serial host command engine driving a 32-bit single-port register SRAM.
// Optional auto-increment opcodes are enabled by defining SRAM_HOST_AUTOINC_EN.
module sram_host_port #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_write,
    output logic [31:0]           o_sram_wdata,
    input  logic [31:0]           i_sram_rdata,
    output logic                  o_busy,
    output logic                  o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WRITE,
        S_READ,
        S_RDATA
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
`ifdef SRAM_HOST_AUTOINC_EN
    localparam logic [7:0] OP_WNEXT = 8'h03;
    localparam logic [7:0] OP_RNEXT = 8'h04;
`endif

    state_t      state;
    logic        op_write;
    logic [1:0]  cnt;
    logic [31:0] tx_shift;
    logic        rx_fire;
    logic        tx_fire;

    // Handshake outputs are pure decodes of the state register.
    assign o_rx_ready = (state == S_IDLE) || (state == S_ADDR) ||
                        (state == S_WDATA);
    assign o_tx_valid = (state == S_RDATA);
    assign o_busy     = (state != S_IDLE);
    assign o_tx_data  = tx_shift[31:24];

    assign rx_fire = i_rx_valid && o_rx_ready;
    assign tx_fire = o_tx_valid && i_tx_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            op_write     <= 1'b0;
            cnt          <= 2'd0;
            tx_shift     <= 32'd0;
            o_sram_addr  <= '0;
            o_sram_write <= 1'b0;
            o_sram_wdata <= 32'd0;
            o_err        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        case (i_rx_data)
                            OP_NOP: begin
                                o_err <= 1'b0;
                            end
                            OP_WRITE: begin
                                op_write <= 1'b1;
                                state    <= S_ADDR;
                            end
                            OP_READ: begin
                                op_write <= 1'b0;
                                state    <= S_ADDR;
                            end
`ifdef SRAM_HOST_AUTOINC_EN
                            OP_WNEXT: begin
                                op_write <= 1'b1;
                                cnt      <= 2'd0;
                                state    <= S_WDATA;
                            end
                            OP_RNEXT: begin
                                op_write <= 1'b0;
                                state    <= S_READ;
                            end
`endif
                            default: begin
                                o_err <= 1'b1;
                            end
                        endcase
                    end
                end

                S_ADDR: begin
                    if (rx_fire) begin
                        o_sram_addr <= i_rx_data[ADDR_WIDTH-1:0];
                        cnt         <= 2'd0;
                        state       <= op_write ? S_WDATA : S_READ;
                    end
                end

                S_WDATA: begin
                    if (rx_fire) begin
                        o_sram_wdata <= {o_sram_wdata[23:0], i_rx_data};
                        cnt          <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            o_sram_write <= 1'b1;
                            state        <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    o_sram_write <= 1'b0;
                    state        <= S_IDLE;
`ifdef SRAM_HOST_AUTOINC_EN
                    o_sram_addr  <= o_sram_addr + ADDR_WIDTH'(1);
`endif
                end

                S_READ: begin
                    tx_shift <= i_sram_rdata;
                    cnt      <= 2'd0;
                    state    <= S_RDATA;
                end

                S_RDATA: begin
                    if (tx_fire) begin
                        tx_shift <= {tx_shift[23:0], 8'h00};
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= S_IDLE;
`ifdef SRAM_HOST_AUTOINC_EN
                            o_sram_addr <= o_sram_addr + ADDR_WIDTH'(1);
`endif
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_host_port.sv
// Directed scoreboard bench for sram_host_port: writes, reads, back-pressure,
// illegal opcodes, reset mid-command and the optional auto-increment opcodes.
module tb_sram_host_port;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic [7:0]  o_sram_addr;
    logic        o_sram_write;
    logic [31:0] o_sram_wdata;
    logic [31:0] i_sram_rdata = 32'h0;
    logic        o_busy;
    logic        o_err;

    int total = 0;
    int bad = 0;
    int wr_seen = 0;
    wr_t wr_q[$];
    logic [7:0] tx_q[$];

    sram_host_port #(.ADDR_WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rx_ready  (o_rx_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_sram_addr (o_sram_addr),
        .o_sram_write(o_sram_write),
        .o_sram_wdata(o_sram_wdata),
        .i_sram_rdata(i_sram_rdata),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write-strobe scoreboard.
    always @(negedge i_clk) begin
        if (!i_rst && o_sram_write) begin
            wr_seen++;
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("write_addr", {24'd0, o_sram_addr}, {24'd0, e.a});
                chk("write_data", o_sram_wdata, e.d);
            end
        end
    end

    // Read-byte scoreboard; the byte transfers at the coming rising edge.
    always @(negedge i_clk) begin
        if (!i_rst && o_tx_valid && i_tx_ready) begin
            if (tx_q.size() == 0) begin
                chk("unexpected_tx", 32'd1, 32'd0);
            end else begin
                logic [7:0] eb;
                eb = tx_q.pop_front();
                chk("tx_byte", {24'd0, o_tx_data}, {24'd0, eb});
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) step();
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        n = 0;
        while (!o_rx_ready && n < 100) begin
            step();
            n++;
        end
        if (!o_rx_ready) chk("rx_timeout", 32'd1, 32'd0);
        step();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic push_tx(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 60) begin
            step();
            n++;
        end
        chk(tag, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wr_q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, o_rx_ready}, 32'd1);
        chk({tag, "_tx_valid"}, {31'd0, o_tx_valid}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, o_tx_data}, 32'd0);
        chk({tag, "_addr"}, {24'd0, o_sram_addr}, 32'd0);
        chk({tag, "_write"}, {31'd0, o_sram_write}, 32'd0);
        chk({tag, "_wdata"}, o_sram_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
    endtask

    initial begin
        int n;
        int w0;
        // Reset
        #2;
        chk_reset_vals("rst");
        step();
        step();
        i_rst = 1'b0;
        step();

        // Plain write
        push_wr(8'h10, 32'hDEADBEEF);
        send(8'h01, 0);
        send(8'h10, 0);
        send(8'hDE, 0);
        send(8'hAD, 0);
        send(8'hBE, 0);
        send(8'hEF, 0);
        chk("wr_strobe_now", {31'd0, o_sram_write}, 32'd1);
        chk("wr_rx_ready_low", {31'd0, o_rx_ready}, 32'd0);
        step();
        chk("wr_strobe_off", {31'd0, o_sram_write}, 32'd0);
        chk("wr_busy_off", {31'd0, o_busy}, 32'd0);
        chk("wr_count1", wr_seen, 32'd1);

        // Plain read, latency check
        i_sram_rdata = 32'hCAFEF00D;
        push_tx(32'hCAFEF00D);
        send(8'h02, 0);
        send(8'h10, 0);
        chk("rd_valid_lat1", {31'd0, o_tx_valid}, 32'd0);
        step();
        chk("rd_valid_lat2", {31'd0, o_tx_valid}, 32'd1);
        chk("rd_first_byte", {24'd0, o_tx_data}, 32'hCA);
        wait_idle("rd_done");
        chk("rd_no_write", wr_seen, 32'd1);

        // Read with tx back-pressure on the second byte
        i_sram_rdata = 32'hCAFEF00D;
        push_tx(32'hCAFEF00D);
        i_tx_ready = 1'b0;
        send(8'h02, 0);
        send(8'h11, 0);
        step();
        i_tx_ready = 1'b1;
        step();
        i_tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_data", {24'd0, o_tx_data}, 32'hFE);
            chk("bp_hold_valid", {31'd0, o_tx_valid}, 32'd1);
            step();
        end
        i_tx_ready = 1'b1;
        wait_idle("bp_done");

        // Write with rx gaps
        push_wr(8'h30, 32'hDEADBEEF);
        send(8'h01, 2);
        send(8'h30, 1);
        send(8'hDE, 3);
        send(8'hAD, 0);
        send(8'hBE, 2);
        send(8'hEF, 1);
        wait_idle("gap_done");
        chk("gap_count", wr_seen, 32'd2);

        // Illegal opcode, then read, then NOP clears the flag
        send(8'h7F, 0);
        chk("ill_err", {31'd0, o_err}, 32'd1);
        chk("ill_idle", {31'd0, o_busy}, 32'd0);
        i_sram_rdata = 32'h13579BDF;
        push_tx(32'h13579BDF);
        send(8'h02, 0);
        send(8'h05, 0);
        wait_idle("ill_rd_done");
        chk("ill_err_sticky", {31'd0, o_err}, 32'd1);
`ifndef SRAM_HOST_AUTOINC_EN
        chk("addr_held", {24'd0, o_sram_addr}, 32'h05);
`endif
        send(8'h00, 0);
        chk("nop_clears_err", {31'd0, o_err}, 32'd0);

        // Reset in the middle of a write
        w0 = wr_seen;
        send(8'h01, 0);
        send(8'h20, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        i_rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        step();
        step();
        i_rst = 1'b0;
        step();
        chk("midrst_no_write", wr_seen, w0);
        i_sram_rdata = 32'h01234567;
        push_tx(32'h01234567);
        send(8'h02, 0);
        send(8'h20, 0);
        wait_idle("midrst_rd_done");

`ifdef SRAM_HOST_AUTOINC_EN
        push_wr(8'hFF, 32'h00000001);
        push_wr(8'h00, 32'h00000002);
        send(8'h01, 0);
        send(8'hFF, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        wait_idle("ai_w1_done");
        chk("ai_wrap_addr", {24'd0, o_sram_addr}, 32'h00);
        send(8'h03, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h02, 0);
        wait_idle("ai_w2_done");
        chk("ai_next_addr", {24'd0, o_sram_addr}, 32'h01);
        chk("ai_no_err", {31'd0, o_err}, 32'd0);
`else
        send(8'h03, 0);
        chk("op03_err", {31'd0, o_err}, 32'd1);
        chk("op03_idle", {31'd0, o_busy}, 32'd0);
        send(8'h00, 0);
`endif

        // Drain scoreboards
        n = 0;
        while ((wr_q.size() != 0 || tx_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        chk("wr_q_empty", wr_q.size(), 32'd0);
        chk("tx_q_empty", tx_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
